// File: rtl/cgra_pkg.sv
// ============================================================================
// Module  : cgra_pkg
// Brief   : Shared types and constants for the reconfigurable-cell sequencer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package cgra_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EXEC  = 2'd1,
        STALL = 2'd2,
        DONE  = 2'd3
    } rcs_pc_state_t;

    localparam int RCS_NUM_CREG_LOG2 = 5;
    localparam int ALU_N_FLAG        = 2;
    localparam int RCS_STALL_CYCLES  = 1;
    localparam int RCS_STALL_CNT_W   = 3;

endpackage

`default_nettype wire

// File: rtl/rcs_pc_ctrl.sv
// ============================================================================
// Module  : rcs_pc_ctrl
// Brief   : Per-RC program-counter sequencer: steps/branches the context PC,
//           freezes it over multi-cycle ALU ops and registers ALU flags.
//           Optional macro RCS_PC_CTRL_CYCLE_CNT_EN adds a kernel cycle counter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rcs_pc_ctrl
    import cgra_pkg::*;
#(
    parameter int RCS_NUM_CREG = 1 << cgra_pkg::RCS_NUM_CREG_LOG2,
    parameter int ALU_N_FLAG   = cgra_pkg::ALU_N_FLAG,
    parameter int STALL_CYCLES = cgra_pkg::RCS_STALL_CYCLES,
    localparam int PC_W        = $clog2(RCS_NUM_CREG)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    input  logic [PC_W-1:0]       start_pc_i,
    input  logic                  exit_i,
    input  logic                  br_req_i,
    input  logic [PC_W-1:0]       br_add_i,
    input  logic                  alu_stall_i,
    input  logic [ALU_N_FLAG-1:0] flag_i,
    output logic [PC_W-1:0]       pc_o,
    output logic                  pc_valid_o,
    output logic                  retire_o,
    output logic [ALU_N_FLAG-1:0] flag_o,
    output logic                  busy_o,
    output logic                  done_o
`ifdef RCS_PC_CTRL_CYCLE_CNT_EN
    ,
    output logic [31:0]           cycle_cnt_o
`endif
);

    localparam int CNT_W = cgra_pkg::RCS_STALL_CNT_W;

    rcs_pc_state_t         r_state;
    rcs_pc_state_t         w_state_nxt;
    logic [PC_W-1:0]       r_pc;
    logic [PC_W-1:0]       w_pc_nxt;
    logic [ALU_N_FLAG-1:0] r_flag;
    logic [ALU_N_FLAG-1:0] w_flag_nxt;
    logic [CNT_W-1:0]      r_stall_cnt;
    logic [CNT_W-1:0]      w_stall_cnt_nxt;
    logic                  w_retire;
    logic                  w_pc_valid;
    logic                  w_done;

    always_comb begin
        w_state_nxt     = r_state;
        w_pc_nxt        = r_pc;
        w_flag_nxt      = r_flag;
        w_stall_cnt_nxt = r_stall_cnt;
        w_retire        = 1'b0;
        w_pc_valid      = 1'b0;
        w_done          = 1'b0;

        case (r_state)
            IDLE: begin
                if (start_i) begin
                    w_pc_nxt    = start_pc_i;
                    w_state_nxt = EXEC;
                end
            end
            EXEC: begin
                w_pc_valid = 1'b1;
                if (alu_stall_i) begin
                    w_stall_cnt_nxt = CNT_W'(STALL_CYCLES);
                    w_state_nxt     = STALL;
                end else begin
                    w_retire = 1'b1;
                end
            end
            STALL: begin
                // alu_stall_i is deliberately ignored; the count alone ends the stall
                w_pc_valid = 1'b1;
                if (r_stall_cnt > CNT_W'(1)) begin
                    w_stall_cnt_nxt = r_stall_cnt - CNT_W'(1);
                end else begin
                    w_retire        = 1'b1;
                    w_stall_cnt_nxt = '0;
                    w_state_nxt     = EXEC;
                end
            end
            DONE: begin
                w_done      = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase

        if (w_retire) begin
            w_flag_nxt = flag_i;
            if (exit_i) begin
                w_state_nxt = DONE;
            end else if (br_req_i) begin
                w_pc_nxt = br_add_i;
            end else begin
                w_pc_nxt = r_pc + PC_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state     <= IDLE;
            r_pc        <= '0;
            r_flag      <= '0;
            r_stall_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_pc        <= w_pc_nxt;
            r_flag      <= w_flag_nxt;
            r_stall_cnt <= w_stall_cnt_nxt;
        end
    end

`ifdef RCS_PC_CTRL_CYCLE_CNT_EN
    logic [31:0] r_cycle_cnt;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_cycle_cnt <= '0;
        end else if (r_state == IDLE && start_i) begin
            r_cycle_cnt <= '0;
        end else if ((r_state == EXEC || r_state == STALL) &&
                     r_cycle_cnt != 32'hFFFF_FFFF) begin
            r_cycle_cnt <= r_cycle_cnt + 32'd1;
        end
    end

    assign cycle_cnt_o = r_cycle_cnt;
`endif

    assign pc_o       = r_pc;
    assign pc_valid_o = w_pc_valid;
    assign retire_o   = w_retire;
    assign flag_o     = r_flag;
    assign busy_o     = (r_state != IDLE);
    assign done_o     = w_done;

endmodule

`default_nettype wire

// File: tb/tb_rcs_pc_ctrl.sv
// ============================================================================
// Module  : tb_rcs_pc_ctrl
// Brief   : Self-checking bench for rcs_pc_ctrl; kernels are described as
//           instruction lists and expanded into expected per-cycle traces.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rcs_pc_ctrl;

    localparam int NC = 32;
    localparam int PW = 5;
    localparam int S  = 2;

    typedef struct packed {
        logic          start;
        logic [PW-1:0] spc;
        logic          ex;
        logic          br;
        logic [PW-1:0] add;
        logic          stl;
        logic [1:0]    flg;
    } stim_t;

    typedef struct packed {
        logic [PW-1:0] pc;
        logic          vld;
        logic          ret;
        logic [1:0]    flg;
        logic          busy;
        logic          done;
    } obs_t;

    typedef struct packed {
        logic          stl;
        logic          ex;
        logic          br;
        logic [PW-1:0] add;
        logic [1:0]    flg;
    } instr_t;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [PW-1:0] start_pc;
    logic          exit_s;
    logic          br_req;
    logic [PW-1:0] br_add;
    logic          alu_stall;
    logic [1:0]    flag_in;
    logic [PW-1:0] pc;
    logic          pc_valid;
    logic          retire;
    logic [1:0]    flag_out;
    logic          busy;
    logic          done;
`ifdef RCS_PC_CTRL_CYCLE_CNT_EN
    logic [31:0]   cycle_cnt;
`endif

    rcs_pc_ctrl #(
        .RCS_NUM_CREG (NC),
        .ALU_N_FLAG   (2),
        .STALL_CYCLES (S)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .start_i     (start),
        .start_pc_i  (start_pc),
        .exit_i      (exit_s),
        .br_req_i    (br_req),
        .br_add_i    (br_add),
        .alu_stall_i (alu_stall),
        .flag_i      (flag_in),
        .pc_o        (pc),
        .pc_valid_o  (pc_valid),
        .retire_o    (retire),
        .flag_o      (flag_out),
        .busy_o      (busy),
        .done_o      (done)
`ifdef RCS_PC_CTRL_CYCLE_CNT_EN
        ,
        .cycle_cnt_o (cycle_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int            checks   = 0;
    int            failures = 0;
    stim_t         stim_q[$];
    obs_t          exp_q[$];
    logic [PW-1:0] pc_m   = '0;
    logic [1:0]    flag_m = '0;
    int            cyc_m  = 0;

    function automatic stim_t junk();
        stim_t s;
        s.start = 1'($urandom_range(0, 1));
        s.spc   = PW'($urandom);
        s.ex    = 1'($urandom_range(0, 1));
        s.br    = 1'($urandom_range(0, 1));
        s.add   = PW'($urandom);
        s.stl   = 1'($urandom_range(0, 1));
        s.flg   = 2'($urandom);
        return s;
    endfunction

    function automatic string fmt(obs_t v);
        return $sformatf("pc=%0d vld=%b ret=%b flg=%b busy=%b done=%b",
                         v.pc, v.vld, v.ret, v.flg, v.busy, v.done);
    endfunction

    function automatic instr_t mk(logic stl, logic ex, logic br, logic [PW-1:0] add,
                                  logic [1:0] flg);
        instr_t i;
        i.stl = stl; i.ex = ex; i.br = br; i.add = add; i.flg = flg;
        return i;
    endfunction

    // Reference: a kernel is a list of instructions; each costs 1 cycle, or
    // 1+S if it stalls, and its retire decides where the PC goes next.
    task automatic build(input logic [PW-1:0] spc, input instr_t prog[$]);
        stim_t s;
        s = junk(); s.start = 1'b1; s.spc = spc;
        stim_q.push_back(s);
        exp_q.push_back(obs_t'({pc_m, 1'b0, 1'b0, flag_m, 1'b0, 1'b0}));
        pc_m  = spc;
        cyc_m = 0;
        foreach (prog[i]) begin
            if (prog[i].stl) begin
                s = junk(); s.stl = 1'b1;
                stim_q.push_back(s);
                exp_q.push_back(obs_t'({pc_m, 1'b1, 1'b0, flag_m, 1'b1, 1'b0}));
                cyc_m++;
                for (int k = 1; k < S; k++) begin
                    s = junk();
                    stim_q.push_back(s);
                    exp_q.push_back(obs_t'({pc_m, 1'b1, 1'b0, flag_m, 1'b1, 1'b0}));
                    cyc_m++;
                end
            end
            s = junk();
            if (!prog[i].stl) s.stl = 1'b0;
            s.ex = prog[i].ex; s.br = prog[i].br; s.add = prog[i].add; s.flg = prog[i].flg;
            stim_q.push_back(s);
            exp_q.push_back(obs_t'({pc_m, 1'b1, 1'b1, flag_m, 1'b1, 1'b0}));
            cyc_m++;
            flag_m = prog[i].flg;
            if (prog[i].ex) break;
            pc_m = prog[i].br ? prog[i].add : PW'((int'(pc_m) + 1) % NC);
        end
        s = junk();
        stim_q.push_back(s);
        exp_q.push_back(obs_t'({pc_m, 1'b0, 1'b0, flag_m, 1'b1, 1'b1}));
        s = junk(); s.start = 1'b0;
        stim_q.push_back(s);
        exp_q.push_back(obs_t'({pc_m, 1'b0, 1'b0, flag_m, 1'b0, 1'b0}));
    endtask

    task automatic step(input stim_t s, output obs_t o);
        start = s.start; start_pc = s.spc; exit_s = s.ex; br_req = s.br;
        br_add = s.add; alu_stall = s.stl; flag_in = s.flg;
        @(negedge clk);
        o = {pc, pc_valid, retire, flag_out, busy, done};
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        obs_t o;
        stim_t s;
        rst_n = 1'b0;
        s = junk(); s.start = 1'b1;
        step(s, o);
        s = junk(); s.start = 1'b1;
        step(s, o);
        checks++;
        if (o !== obs_t'(0)) begin
            failures++;
            $display("FAIL reset: got %s expected all zero", fmt(o));
        end
        rst_n = 1'b1;
        pc_m = '0; flag_m = '0;
    endtask

    task automatic test_linear();
        obs_t o, e;
        instr_t p[$];
        for (int i = 0; i < 4; i++) p.push_back(mk(1'b0, i == 3, 1'b0, '0, 2'($urandom)));
        build(5'd4, p);
        while (stim_q.size() > 0) begin
            step(stim_q.pop_front(), o); e = exp_q.pop_front(); checks++;
            if (o !== e) begin failures++; $display("FAIL linear: got %s expected %s", fmt(o), fmt(e)); end
        end
    endtask

    task automatic test_branch_wrap();
        obs_t o, e;
        instr_t p[$];
        p = '{mk(0, 0, 0, 0, 2'b01), mk(0, 0, 0, 0, 2'b00), mk(0, 0, 0, 0, 2'b11),
              mk(0, 0, 1, 5'd12, 2'b10), mk(0, 1, 0, 0, 2'b01)};
        build(5'd30, p);
        while (stim_q.size() > 0) begin
            step(stim_q.pop_front(), o); e = exp_q.pop_front(); checks++;
            if (o !== e) begin failures++; $display("FAIL branch_wrap: got %s expected %s", fmt(o), fmt(e)); end
        end
    endtask

    task automatic test_stall();
        obs_t o, e;
        instr_t p[$];
        p = '{mk(1, 0, 0, 0, 2'b10), mk(0, 1, 0, 0, 2'b00)};
        build(5'd5, p);
        while (stim_q.size() > 0) begin
            step(stim_q.pop_front(), o); e = exp_q.pop_front(); checks++;
            if (o !== e) begin failures++; $display("FAIL stall: got %s expected %s", fmt(o), fmt(e)); end
        end
    endtask

    task automatic test_exit_vs_branch();
        obs_t o, e;
        instr_t p[$];
        p = '{mk(0, 0, 0, 0, 2'b01), mk(0, 1, 1, 5'd3, 2'b11)};
        build(5'd9, p);
        while (stim_q.size() > 0) begin
            step(stim_q.pop_front(), o); e = exp_q.pop_front(); checks++;
            if (o !== e) begin failures++; $display("FAIL exit_vs_branch: got %s expected %s", fmt(o), fmt(e)); end
        end
    endtask

    task automatic test_reset_mid_stall();
        obs_t o, e;
        stim_t s;
        instr_t p[$];
        p = '{mk(0, 0, 0, 0, 2'b11), mk(1, 0, 0, 0, 2'b01), mk(0, 1, 0, 0, 2'b10)};
        build(5'd17, p);
        // start, one retire, EXEC with stall, first STALL cycle
        for (int n = 0; n < 4; n++) begin
            step(stim_q.pop_front(), o); e = exp_q.pop_front(); checks++;
            if (o !== e) begin failures++; $display("FAIL mid_stall_pre: got %s expected %s", fmt(o), fmt(e)); end
        end
        stim_q.delete(); exp_q.delete();
        rst_n = 1'b0;
        s = junk(); s.start = 1'b1;
        step(s, o);
        rst_n = 1'b1;
        pc_m = '0; flag_m = '0;
        s = junk(); s.start = 1'b0;
        step(s, o); checks++;
        if (o !== obs_t'(0)) begin
            failures++;
            $display("FAIL mid_stall_reset: got %s expected all zero", fmt(o));
        end
        p = '{mk(1, 0, 1, 5'd2, 2'b10), mk(1, 1, 0, 0, 2'b01)};
        build(5'd20, p);
        while (stim_q.size() > 0) begin
            step(stim_q.pop_front(), o); e = exp_q.pop_front(); checks++;
            if (o !== e) begin failures++; $display("FAIL mid_stall_post: got %s expected %s", fmt(o), fmt(e)); end
        end
    endtask

    task automatic test_random();
        obs_t o, e;
        instr_t p[$];
        for (int k = 0; k < 25; k++) begin
            int len;
            p.delete();
            len = $urandom_range(1, 8);
            for (int i = 0; i < len; i++)
                p.push_back(mk($urandom_range(0, 9) < 3, i == len - 1, $urandom_range(0, 9) < 3,
                               PW'($urandom), 2'($urandom)));
            build(PW'($urandom), p);
            while (stim_q.size() > 0) begin
                step(stim_q.pop_front(), o); e = exp_q.pop_front(); checks++;
                if (o !== e) begin failures++; $display("FAIL random k=%0d: got %s expected %s", k, fmt(o), fmt(e)); end
            end
        end
    endtask

`ifdef RCS_PC_CTRL_CYCLE_CNT_EN
    task automatic test_cycle_cnt();
        obs_t o, e;
        stim_t s;
        instr_t p[$];
        p = '{mk(0, 0, 0, 0, 2'b00), mk(1, 0, 0, 0, 2'b01), mk(0, 0, 0, 0, 2'b10), mk(0, 1, 0, 0, 2'b11)};
        build(5'd8, p);
        while (stim_q.size() > 0) begin
            step(stim_q.pop_front(), o); e = exp_q.pop_front(); checks++;
            if (o !== e) begin failures++; $display("FAIL cycle_kernel: got %s expected %s", fmt(o), fmt(e)); end
        end
        checks++;
        if (cycle_cnt !== 32'(cyc_m)) begin
            failures++; $display("FAIL cycle_cnt_done: got %0d expected %0d", cycle_cnt, cyc_m);
        end
        for (int n = 0; n < 3; n++) begin
            s = junk(); s.start = 1'b0; step(s, o);
        end
        checks++;
        if (cycle_cnt !== 32'(cyc_m)) begin
            failures++; $display("FAIL cycle_cnt_hold: got %0d expected %0d", cycle_cnt, cyc_m);
        end
        p = '{mk(0, 1, 0, 0, 2'b00)};
        build(5'd1, p);
        step(stim_q.pop_front(), o); void'(exp_q.pop_front());
        checks++;
        if (cycle_cnt !== 32'd0) begin
            failures++; $display("FAIL cycle_cnt_clear: got %0d expected 0", cycle_cnt);
        end
        while (stim_q.size() > 0) begin
            step(stim_q.pop_front(), o); e = exp_q.pop_front(); checks++;
            if (o !== e) begin failures++; $display("FAIL cycle_kernel2: got %s expected %s", fmt(o), fmt(e)); end
        end
        checks++;
        if (cycle_cnt !== 32'd1) begin
            failures++; $display("FAIL cycle_cnt_one: got %0d expected 1", cycle_cnt);
        end
    endtask
`endif

    initial begin
        rst_n = 1'b0; start = 1'b0; start_pc = '0; exit_s = 1'b0; br_req = 1'b0;
        br_add = '0; alu_stall = 1'b0; flag_in = '0;
        @(posedge clk); #1;
        test_reset();
        test_linear();
        test_branch_wrap();
        test_stall();
        test_exit_vs_branch();
        test_reset_mid_stall();
        test_random();
`ifdef RCS_PC_CTRL_CYCLE_CNT_EN
        test_cycle_cnt();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
